// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BIDX_W = 3;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   localparam logic LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Pop-side handshake between an upstream FIFO and the UART transmitter.
interface fifo_uart_tx_if;
   import uart_pkg::*;

   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_pop;

   // Transmitter side: consumes the FIFO.
   modport master (input fifo_empty, input fifo_data, output fifo_pop);
   // FIFO side: supplies data on request.
   modport slave  (output fifo_empty, output fifo_data, input fifo_pop);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_done
);

   logic [CNT_W-1:0] cnt;

   // Free-running count, zeroed on frame load and at every bit boundary.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them LSB first.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy
);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic [BIDX_W-1:0] bit_idx, bit_idx_nxt;
   logic              stop_idx, stop_idx_nxt;
   logic              par_acc, par_acc_nxt;
   logic              tx_nxt;
   logic              bit_done;
   logic              timer_clear_c;

   assign timer_clear_c = (state == ST_LOAD) | bit_done;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear_c),
      .bit_done (bit_done)
   );

   // Next-state, datapath and next line level.
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      bit_idx_nxt  = bit_idx;
      stop_idx_nxt = stop_idx;
      par_acc_nxt  = par_acc;
      tx_nxt       = LINE_IDLE;

      case (state)
         ST_IDLE: begin
            if (!fifo.fifo_empty) state_nxt = ST_POP;
         end
         ST_POP: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            shreg_nxt    = fifo.fifo_data;
            bit_idx_nxt  = '0;
            stop_idx_nxt = 1'b0;
            par_acc_nxt  = 1'b0;
            state_nxt    = ST_START;
         end
         ST_START: begin
            if (bit_done) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bit_done) begin
               par_acc_nxt = par_acc ^ shreg[0];
               shreg_nxt   = {1'b0, shreg[DATA_W-1:1]};
               if (bit_idx == BIDX_W'(DATA_W - 1)) begin
                  state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_nxt = bit_idx + BIDX_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (bit_done) begin
               if (stop_idx == 1'(STOP_BITS - 1)) begin
                  state_nxt = ST_IDLE;
               end else begin
                  stop_idx_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Line level is decided from where the FSM is heading so tx comes straight from a flop.
      case (state_nxt)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = shreg_nxt[0];
         ST_PARITY: tx_nxt = (PARITY == PARITY_ODD) ? ~par_acc_nxt : par_acc_nxt;
         default:   tx_nxt = LINE_IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         shreg         <= '0;
         bit_idx       <= '0;
         stop_idx      <= 1'b0;
         par_acc       <= 1'b0;
         tx            <= LINE_IDLE;
         busy          <= 1'b0;
         fifo.fifo_pop <= 1'b0;
      end else begin
         state         <= state_nxt;
         shreg         <= shreg_nxt;
         bit_idx       <= bit_idx_nxt;
         stop_idx      <= stop_idx_nxt;
         par_acc       <= par_acc_nxt;
         tx            <= tx_nxt;
         busy          <= (state_nxt != ST_IDLE);
         fifo.fifo_pop <= (state_nxt == ST_POP);
      end
   end

endmodule
